multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle main control FSM for the CPU datapath. It sequences each instruction through fetch, decode, execute, memory and write-back. It drives the datapath mux and enable signals and produces the 3-bit `alu_op` consumed by `alu_control`: `3'b111` means "decode function field", and any other value is passed straight through as the ALU control code. Memory accesses stall on a `mem_ready` handshake.

## Interface
- `clk`  in  1  — single system clock; all state changes on the rising edge.
- `reset`  in  1  — asynchronous, active-high; forces state INIT immediately.
- `opcode`  in  6  — instruction opcode from the instruction register; stable from DECODE until the next FETCH.
- `mem_ready`  in  1  — memory handshake; sampled only in FETCH, MEM_RD and MEM_WR.
- `alu_op`  out  3  — to `alu_control`: 000 = add, 101 = sub, 111 = R-type.
- `alu_src_a`  out  1  — 0 = PC, 1 = register A.
- `alu_src_b`  out  2  — 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `mem_read`, `mem_write`, `iord`, `ir_write`, `reg_write`, `reg_dst`, `mem_to_reg`, `pc_write`, `pc_write_cond`  out  1 each  — datapath enables and selects.
- `pc_source`  out  2  — 00 = ALU result, 01 = ALUOut register, 10 = jump target.
- `illegal_op`  out  1  — high during a DECODE cycle whose opcode is unsupported.
- `state`  out  4  — current state encoding, for debug and verification.

## Operation
- State register: 4 bits. Encodings: INIT=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, WB_MEM=5, MEM_WR=6, EXEC_R=7, WB_R=8, BRANCH=9, ADDI_EXEC=10, ADDI_WB=11, JUMP=12.
- Encodings 13–15 are unreachable; if entered, go to FETCH with all outputs 0.
- Outputs are Moore decodes of `state`. The exceptions are `ir_write`/`pc_write` in FETCH and `illegal_op` in DECODE, which also depend on inputs.
- Any output not listed for a state is 0.
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- States, outputs and transitions:
  - INIT: all outputs 0 → FETCH.
  - FETCH: `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=000, `pc_source`=00, `ir_write`=`pc_write`=`mem_ready`. Stay while `mem_ready`=0; → DECODE when `mem_ready`=1.
  - DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=000 (branch target precompute).
    - lw/sw → MEM_ADDR; R-type → EXEC_R; beq → BRANCH; addi → ADDI_EXEC; j → JUMP.
    - Any other opcode: `illegal_op`=1 → FETCH.
  - MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=000. lw → MEM_RD; sw → MEM_WR.
  - MEM_RD: `mem_read`=1, `iord`=1. Stay until `mem_ready` → WB_MEM.
  - WB_MEM: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0 → FETCH.
  - MEM_WR: `mem_write`=1, `iord`=1. Stay until `mem_ready` → FETCH.
  - EXEC_R: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=111 → WB_R.
  - WB_R: `reg_write`=1, `reg_dst`=1 → FETCH.
  - BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=101, `pc_write_cond`=1, `pc_source`=01 → FETCH.
  - ADDI_EXEC: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=000 → ADDI_WB.
  - ADDI_WB: `reg_write`=1, `reg_dst`=0 → FETCH.
  - JUMP: `pc_write`=1, `pc_source`=10 → FETCH.
- `alu_op`=111 appears only in EXEC_R. `mem_read` and `mem_write` are never high together.

## Timing
- Reset: `state`=0 and every output 0 while `reset` is high. This takes effect asynchronously, including mid-MEM_WR: `mem_write` drops without waiting for a clock.
- First FETCH is the cycle after `reset` deasserts.
- Cycles per instruction with zero wait: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4, illegal 2.
- Each `mem_ready`=0 cycle in FETCH/MEM_RD/MEM_WR adds exactly one cycle. Outputs hold constant during stalls, and `ir_write`/`pc_write` stay 0.
- `mem_ready` in any other state is ignored.
- `opcode` changing mid-instruction after DECODE has no effect, except the lw/sw choice taken in MEM_ADDR.

## Test plan
- Reset: assert `reset` mid-MEM_WR → `state`=0 and `mem_write`=0 immediately, before the next edge. Release → INIT for one cycle, then FETCH with `mem_read`=1.
- R-type with `mem_ready`=1: state sequence 1,2,7,8,1. `alu_op`=111 only in state 7; `reg_write`=`reg_dst`=1 in state 8.
- lw with `mem_ready` low for 3 cycles in MEM_RD: sequence 1,2,3,4,4,4,4,5,1 → `mem_to_reg`=`reg_write`=1 exactly once.
- sw, then beq, then j: `mem_write` for one cycle with `iord`=1. BRANCH shows `alu_op`=101, `pc_write_cond`=1, `pc_source`=01. JUMP shows `pc_write`=1, `pc_source`=10.
- Fetch stall: `mem_ready`=0 for 2 cycles in FETCH → `ir_write`/`pc_write` stay 0, then pulse high for exactly one cycle.
- Illegal opcode 111111: DECODE asserts `illegal_op`=1 for one cycle → FETCH next cycle; no `reg_write` or `mem_write` asserted.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM: sequences fetch, decode, execute, memory
// and write-back, driving datapath selects/enables and the alu_control code.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic [2:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        INIT      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_RD    = 4'd4,
        WB_MEM    = 4'd5,
        MEM_WR    = 4'd6,
        EXEC_R    = 4'd7,
        WB_R      = 4'd8,
        BRANCH    = 4'd9,
        ADDI_EXEC = 4'd10,
        ADDI_WB   = 4'd11,
        JUMP      = 4'd12
    } state_t;

    state_t cur_state;
    state_t next_state;

    assign state = cur_state;

    // State register; reset forces INIT immediately, so every Moore output drops at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= INIT;
        end else begin
            cur_state <= next_state;
        end
    end

    // Next-state and output decode; everything defaults to 0 and to FETCH.
    always_comb begin
        next_state    = FETCH;
        alu_op        = 3'b000;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;

        case (cur_state)
            INIT: begin
                next_state = FETCH;
            end
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                // IR load and PC+4 commit only on the cycle the fetch completes.
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                next_state = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: next_state = MEM_ADDR;
                    OP_RTYPE:     next_state = EXEC_R;
                    OP_BEQ:       next_state = BRANCH;
                    OP_ADDI:      next_state = ADDI_EXEC;
                    OP_J:         next_state = JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        next_state = FETCH;
                    end
                endcase
            end
            MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                next_state = (opcode == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mem_read   = 1'b1;
                iord       = 1'b1;
                next_state = mem_ready ? WB_MEM : MEM_RD;
            end
            WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                next_state = FETCH;
            end
            MEM_WR: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                next_state = mem_ready ? FETCH : MEM_WR;
            end
            EXEC_R: begin
                alu_src_a  = 1'b1;
                alu_op     = 3'b111;
                next_state = WB_R;
            end
            WB_R: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 3'b101;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                next_state    = FETCH;
            end
            ADDI_EXEC: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                next_state = ADDI_WB;
            end
            ADDI_WB: begin
                reg_write  = 1'b1;
                next_state = FETCH;
            end
            JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                next_state = FETCH;
            end
            default: begin
                next_state = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: each instruction is expanded
// into its expected per-cycle trace (state, outputs, stimulus) and replayed.
module tb_multicycle_control;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       illegal_op;
    } outs_t;

    typedef struct packed {
        logic [3:0] st;
        logic       rdy;
        logic [5:0] opc;
        outs_t      o;
    } step_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic [2:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       mem_read, mem_write, iord, ir_write, reg_write, reg_dst;
    logic       mem_to_reg, pc_write, pc_write_cond, illegal_op;
    logic [1:0] pc_source;
    logic [3:0] state;

    outs_t obs;
    assign obs = {alu_op, alu_src_a, alu_src_b, mem_read, mem_write, iord, ir_write,
                  reg_write, reg_dst, mem_to_reg, pc_write, pc_write_cond, pc_source,
                  illegal_op};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    step_t q[$];

    multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .illegal_op(illegal_op), .state(state)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    // Hard time limit so the run can never hang.
    initial begin
        #300000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, required %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] st, input logic rdy, input logic [5:0] opc,
                        input outs_t o);
        step_t e;
        e.st = st; e.rdy = rdy; e.opc = opc; e.o = o;
        q.push_back(e);
    endtask

    // Expected trace of one instruction, written from the instruction's flow.
    task automatic build_instr(input logic [5:0] opc, input int fstall, input int mstall);
        outs_t o;
        logic [5:0] post;
        logic is_lw, is_sw, is_r, is_beq, is_addi, is_j, legal;
        is_lw   = (opc == OP_LW);
        is_sw   = (opc == OP_SW);
        is_r    = (opc == OP_R);
        is_beq  = (opc == OP_BEQ);
        is_addi = (opc == OP_ADDI);
        is_j    = (opc == OP_J);
        legal   = is_lw | is_sw | is_r | is_beq | is_addi | is_j;
        // After decode only lw/sw still look at opcode; scramble it otherwise.
        post = (is_lw || is_sw) ? opc : 6'($urandom);

        for (int i = 0; i < fstall; i++) begin
            o = '0; o.mem_read = 1'b1; o.alu_src_b = 2'b01;
            push(4'd1, 1'b0, 6'($urandom), o);
        end
        o = '0; o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.ir_write = 1'b1; o.pc_write = 1'b1;
        push(4'd1, 1'b1, 6'($urandom), o);

        o = '0; o.alu_src_b = 2'b11; o.illegal_op = !legal;
        push(4'd2, 1'($urandom), opc, o);

        if (is_lw || is_sw) begin
            o = '0; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
            push(4'd3, 1'($urandom), post, o);
            o = '0; o.iord = 1'b1;
            if (is_lw) o.mem_read = 1'b1;
            else       o.mem_write = 1'b1;
            for (int i = 0; i < mstall; i++) push(is_lw ? 4'd4 : 4'd6, 1'b0, post, o);
            push(is_lw ? 4'd4 : 4'd6, 1'b1, post, o);
            if (is_lw) begin
                o = '0; o.reg_write = 1'b1; o.mem_to_reg = 1'b1;
                push(4'd5, 1'($urandom), post, o);
            end
        end else if (is_r) begin
            o = '0; o.alu_src_a = 1'b1; o.alu_op = 3'b111;
            push(4'd7, 1'($urandom), post, o);
            o = '0; o.reg_write = 1'b1; o.reg_dst = 1'b1;
            push(4'd8, 1'($urandom), post, o);
        end else if (is_beq) begin
            o = '0; o.alu_src_a = 1'b1; o.alu_op = 3'b101; o.pc_write_cond = 1'b1;
            o.pc_source = 2'b01;
            push(4'd9, 1'($urandom), post, o);
        end else if (is_addi) begin
            o = '0; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
            push(4'd10, 1'($urandom), post, o);
            o = '0; o.reg_write = 1'b1;
            push(4'd11, 1'($urandom), post, o);
        end else if (is_j) begin
            o = '0; o.pc_write = 1'b1; o.pc_source = 2'b10;
            push(4'd12, 1'($urandom), post, o);
        end
    endtask

    task automatic apply_check(input step_t e);
        mem_ready = e.rdy;
        opcode    = e.opc;
        #1;
        check("state", 32'(state), 32'(e.st));
        check("outputs", 32'(obs), 32'(e.o));
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Replays one instruction; stop_st >= 0 ends after checking that state.
    task automatic run_instr(input logic [5:0] opc, input int fstall, input int mstall,
                             input int stop_st);
        q.delete();
        build_instr(opc, fstall, mstall);
        foreach (q[i]) begin
            apply_check(q[i]);
            if (int'(q[i].st) == stop_st) return;
            advance();
        end
    endtask

    task automatic check_reset_release();
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        #1;
        check("reset_hold_state", 32'(state), 32'd0);
        check("reset_hold_outputs", 32'(obs), 32'd0);
        reset = 1'b0;
        #1;
        check("init_state", 32'(state), 32'd0);
        check("init_outputs", 32'(obs), 32'd0);
        advance();
    endtask

    initial begin
        logic [5:0] ops [6];
        ops[0] = OP_R; ops[1] = OP_LW; ops[2] = OP_SW;
        ops[3] = OP_BEQ; ops[4] = OP_ADDI; ops[5] = OP_J;

        reset = 1'b1;
        mem_ready = 1'b0;
        opcode = '0;
        @(posedge clk);
        check_reset_release();

        run_instr(OP_R, 0, 0, -1);
        run_instr(OP_LW, 0, 3, -1);
        run_instr(OP_SW, 0, 0, -1);
        run_instr(OP_BEQ, 0, 0, -1);
        run_instr(OP_J, 0, 0, -1);
        run_instr(OP_ADDI, 2, 0, -1);
        run_instr(6'b111111, 0, 0, -1);

        // Reset landing in the middle of a stalled store.
        run_instr(OP_SW, 0, 2, 6);
        reset = 1'b1;
        #1;
        check("async_reset_state", 32'(state), 32'd0);
        check("async_reset_mem_write", 32'(mem_write), 32'd0);
        check("async_reset_outputs", 32'(obs), 32'd0);
        check_reset_release();

        for (int n = 0; n < 150; n++) begin
            logic [5:0] opc;
            if ($urandom_range(7) == 0) opc = 6'($urandom);
            else                        opc = ops[$urandom_range(5)];
            run_instr(opc, $urandom_range(3), $urandom_range(3), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
